traffic_mode_sel: RTL

- Upstream stage of the two-approach traffic light controller; produces that controller's 2-bit timing-mode select.
- Counts vehicle-detector pulses on approaches A and B over one full signal cycle and picks a new mode at each cycle boundary.
- Mode changes pass through a hysteresis filter, with a manual override for maintenance.
- Outputs change only at cycle boundaries, so the light controller never sees a mid-cycle mode change.

---
 rtl/traffic_pkg.sv | 19 +
 rtl/det_sync_edge.sv | 31 +++
 rtl/traffic_mode_sel.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Mode-select encoding and selector FSM state type, shared with the light controller.
package traffic_pkg;

   localparam logic [1:0] SEL_NORMAL = 2'b00;
   localparam logic [1:0] SEL_FAV_A  = 2'b01;
   localparam logic [1:0] SEL_FAV_B  = 2'b10;

   typedef enum logic [1:0] {
      STABLE,
      PENDING,
      MANUAL
   } tMODE_STATE;

   // The unused code 11 must never reach the light controller.
   function automatic logic [1:0] legal_sel(input logic [1:0] sel);
      return (sel == 2'b11) ? SEL_NORMAL : sel;
   endfunction

endpackage

// File: rtl/det_sync_edge.sv
// Brings a raw asynchronous detector level into the clk domain and emits
// a one-clock pulse per rising edge of the synchronized level.
module det_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic det_in,
   output logic pulse_out
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // NOTE: non-blocking assignments make the three flops a true shift chain;
   // blocking ones would collapse it into a single register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= det_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // prev_q clears on reset, so a level already high at release reads as one edge.
   assign pulse_out = sync2_q & ~prev_q;

endmodule

// File: rtl/traffic_mode_sel.sv
// Timing-mode selector: counts vehicles per signal cycle on two approaches and
// picks the light controller's mode at each cycle boundary, with hysteresis.
module traffic_mode_sel
   import traffic_pkg::*;
#(
   parameter int CNT_W        = 8,
   parameter int DIFF_TH      = 4,
   parameter int HOLD_WINDOWS = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             det_a_in,
   input  logic             det_b_in,
   input  logic             cycle_end_in,
   input  logic             man_en_in,
   input  logic [1:0]       man_sel_in,
   output logic [1:0]       sel_out,
   output logic [CNT_W-1:0] cnt_a_out,
   output logic [CNT_W-1:0] cnt_b_out,
   output logic             sel_chg_out
);

   localparam logic [CNT_W-1:0]      CNT_MAX = '1;
   localparam logic signed [CNT_W:0] TH      = (CNT_W+1)'(DIFF_TH);
   localparam logic [3:0]            HOLD    = 4'(HOLD_WINDOWS);

   logic                     edge_a;
   logic                     edge_b;
   logic [CNT_W-1:0]         live_a_q;
   logic [CNT_W-1:0]         live_b_q;
   logic [CNT_W-1:0]         cnt_a_q;
   logic [CNT_W-1:0]         cnt_b_q;
   logic                     end_q;
   logic                     eval_q;
   logic signed [CNT_W:0]    diff_ab;
   logic signed [CNT_W:0]    diff_ba;
   logic [1:0]               cand;
   logic [1:0]               cand_q;

   tMODE_STATE               state_q;
   tMODE_STATE               state_d;
   logic [1:0]               sel_q;
   logic [1:0]               sel_d;
   logic [1:0]               pend_q;
   logic [1:0]               pend_d;
   logic [3:0]               agree_q;
   logic [3:0]               agree_d;
   logic                     chg_q;
   logic                     chg_d;

   det_sync_edge u_det_a (
      .clk       (clk),
      .reset_n   (reset_n),
      .det_in    (det_a_in),
      .pulse_out (edge_a)
   );

   det_sync_edge u_det_b (
      .clk       (clk),
      .reset_n   (reset_n),
      .det_in    (det_b_in),
      .pulse_out (edge_b)
   );

   // An edge arriving with the strobe opens the new window rather than closing the old one.
   function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] live,
                                                   input logic             hit,
                                                   input logic             restart);
      if (restart)
         return CNT_W'(hit);
      if (hit && (live != CNT_MAX))
         return live + CNT_W'(1);
      return live;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         live_a_q <= '0;
         live_b_q <= '0;
         cnt_a_q  <= '0;
         cnt_b_q  <= '0;
         end_q    <= 1'b0;
         eval_q   <= 1'b0;
         cand_q   <= SEL_NORMAL;
      end else begin
         live_a_q <= count_next(live_a_q, edge_a, cycle_end_in);
         live_b_q <= count_next(live_b_q, edge_b, cycle_end_in);
         if (cycle_end_in) begin
            cnt_a_q <= live_a_q;
            cnt_b_q <= live_b_q;
         end
         end_q  <= cycle_end_in;
         eval_q <= end_q;
         cand_q <= cand;
      end
   end

   // One extra bit keeps both differences exact for any pair of saturated counts.
   always_comb begin
      diff_ab = $signed({1'b0, cnt_a_q}) - $signed({1'b0, cnt_b_q});
      diff_ba = $signed({1'b0, cnt_b_q}) - $signed({1'b0, cnt_a_q});
      cand    = SEL_NORMAL;
      if (diff_ab >= TH)
         cand = SEL_FAV_A;
      else if (diff_ba >= TH)
         cand = SEL_FAV_B;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= STABLE;
         sel_q   <= SEL_NORMAL;
         pend_q  <= SEL_NORMAL;
         agree_q <= '0;
         chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         pend_q  <= pend_d;
         agree_q <= agree_d;
         chg_q   <= chg_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      pend_d  = pend_q;
      agree_d = agree_q;
      chg_d   = 1'b0;
      if (eval_q) begin
         if (man_en_in) begin
            state_d = MANUAL;
            sel_d   = legal_sel(man_sel_in);
            pend_d  = SEL_NORMAL;
            agree_d = '0;
            chg_d   = (sel_d != sel_q);
         end else if (state_q == PENDING) begin
            if (cand_q == pend_q) begin
               agree_d = agree_q + 4'd1;
               if (agree_d >= HOLD) begin
                  sel_d   = pend_q;
                  chg_d   = 1'b1;
                  agree_d = '0;
                  state_d = STABLE;
               end
            end else if (cand_q == sel_q) begin
               agree_d = '0;
               state_d = STABLE;
            end else begin
               pend_d  = cand_q;
               agree_d = 4'd1;
            end
         end else begin
            // STABLE, or leaving MANUAL: both judge the candidate from scratch.
            state_d = STABLE;
            if (cand_q != sel_q) begin
               if (HOLD == 4'd1) begin
                  sel_d = cand_q;
                  chg_d = 1'b1;
               end else begin
                  pend_d  = cand_q;
                  agree_d = 4'd1;
                  state_d = PENDING;
               end
            end
         end
      end
   end

   assign sel_out     = sel_q;
   assign sel_chg_out = chg_q;
   assign cnt_a_out   = cnt_a_q;
   assign cnt_b_out   = cnt_b_q;

endmodule
